sdram_burst_sched: RTL

SDRAM_BURST_SCHED -- requirements
Module: sdram_burst_sched

---
 rtl/sdram_burst_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_sched.sv
// sdram_burst_sched
//   Arbitrates SDRAM burst requests between the ROM-to-SDRAM write path and
//   the SDRAM-to-VGA read path. Each burst moves one 512-word row. Writes fill
//   a frame of ROWS rows once. After that, reads stream the frame once per
//   active video period, and vertical blank rewinds the read row to 0.
//   An ack watchdog abandons a burst that is never acknowledged and latches
//   tmo_err.
//
// Ports
//   clk_133M      in   clock, rising edge
//   rst_133       in   asynchronous reset, active low
//   vsync_n       in   frame sync (synchronous), low = vertical blank
//   wr_fifo_used  in   [10:0] write FIFO fill level
//   rd_fifo_used  in   [10:0] read FIFO fill level
//   wr_sdram_req  out  write burst request
//   wr_sdram_ack  in   write burst done, one-cycle pulse
//   wr_sdram_add  out  [23:0] write address {bank, row, column}
//   rd_sdram_req  out  read burst request
//   rd_sdram_ack  in   read burst done, one-cycle pulse
//   rd_sdram_add  out  [23:0] read address {bank, row, column}
//   frame_written out  all ROWS write bursts have completed
//   tmo_err       out  sticky ack-watchdog error
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no burst in flight, arbitrate between eligible requesters
// WR_BUSY | wr_sdram_req high, waiting for wr_sdram_ack or timeout
// RD_BUSY | rd_sdram_req high, waiting for rd_sdram_ack or timeout
// GAP     | one forced low cycle between consecutive requests

module sdram_burst_sched #(
   parameter int ROWS      = 128,
   parameter int WR_THRESH = 512,
   parameter int RD_THRESH = 512,
   parameter int TMO       = 4095
) (
   input  logic        clk_133M,
   input  logic        rst_133,
   input  logic        vsync_n,
   input  logic [10:0] wr_fifo_used,
   input  logic [10:0] rd_fifo_used,
   output logic        wr_sdram_req,
   input  logic        wr_sdram_ack,
   output logic [23:0] wr_sdram_add,
   output logic        rd_sdram_req,
   input  logic        rd_sdram_ack,
   output logic [23:0] rd_sdram_add,
   output logic        frame_written,
   output logic        tmo_err
);

   localparam int WD_W = $clog2(TMO + 1);

   localparam logic [10:0]     WR_TH   = 11'(WR_THRESH);
   localparam logic [10:0]     RD_TH   = 11'(RD_THRESH);
   localparam logic [13:0]     ROWS_C  = 14'(ROWS);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TMO - 1);

   localparam logic GRANT_WR = 1'b1;
   localparam logic GRANT_RD = 1'b0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_BUSY = 2'd1,
      RD_BUSY = 2'd2,
      GAP     = 2'd3
   } state_t;

   state_t          state;
   logic [13:0]     wr_row;
   logic [13:0]     rd_row;
   logic [WD_W-1:0] wd_cnt;
   logic            last_grant;

   logic            wr_ok;
   logic            rd_ok;
   logic            wr_ack_hit;
   logic            rd_ack_hit;
   logic [13:0]     wr_row_nxt;
   logic [13:0]     rd_row_nxt;

   assign wr_ok = (wr_fifo_used >= WR_TH) && (wr_row < ROWS_C);
   assign rd_ok = frame_written && vsync_n && (rd_fifo_used <= RD_TH) && (rd_row < ROWS_C);

   // Acks are only meaningful while the matching burst is in flight.
   assign wr_ack_hit = (state == WR_BUSY) && wr_sdram_ack;
   assign rd_ack_hit = (state == RD_BUSY) && rd_sdram_ack;

   // Row counters and address registers load the same next value, so the
   // address outputs never lag the row counters.
   always_comb begin
      wr_row_nxt = wr_row;
      if (wr_ack_hit && (wr_row < ROWS_C))
         wr_row_nxt = wr_row + 1'b1;
   end

   // Vertical blank clears the read row every cycle; it also wins over an
   // ack that completes a read burst during blank.
   always_comb begin
      rd_row_nxt = rd_row;
      if (!vsync_n)
         rd_row_nxt = '0;
      else if (rd_ack_hit)
         rd_row_nxt = rd_row + 1'b1;
   end

   always_ff @(posedge clk_133M or negedge rst_133) begin
      if (!rst_133) begin
         state         <= IDLE;
         wr_sdram_req  <= 1'b0;
         rd_sdram_req  <= 1'b0;
         wr_sdram_add  <= '0;
         rd_sdram_add  <= '0;
         wr_row        <= '0;
         rd_row        <= '0;
         frame_written <= 1'b0;
         tmo_err       <= 1'b0;
         wd_cnt        <= '0;
         last_grant    <= GRANT_WR;
      end else begin
         wr_row       <= wr_row_nxt;
         rd_row       <= rd_row_nxt;
         wr_sdram_add <= {2'b00, wr_row_nxt[12:0], 9'd0};
         rd_sdram_add <= {2'b00, rd_row_nxt[12:0], 9'd0};

         if (wr_row == ROWS_C)
            frame_written <= 1'b1;

         case (state)
            IDLE: begin
               // On a tie the requester not served last wins.
               if (wr_ok && (!rd_ok || (last_grant == GRANT_RD))) begin
                  state        <= WR_BUSY;
                  wr_sdram_req <= 1'b1;
                  last_grant   <= GRANT_WR;
                  wd_cnt       <= WD_LOAD;
               end else if (rd_ok) begin
                  state        <= RD_BUSY;
                  rd_sdram_req <= 1'b1;
                  last_grant   <= GRANT_RD;
                  wd_cnt       <= WD_LOAD;
               end
            end

            WR_BUSY: begin
               // Ack is checked first so a coincident expiry counts as ack.
               if (wr_sdram_ack) begin
                  wr_sdram_req <= 1'b0;
                  state        <= GAP;
               end else if (wd_cnt == '0) begin
                  wr_sdram_req <= 1'b0;
                  tmo_err      <= 1'b1;
                  state        <= GAP;
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
            end

            RD_BUSY: begin
               if (rd_sdram_ack) begin
                  rd_sdram_req <= 1'b0;
                  state        <= GAP;
               end else if (wd_cnt == '0) begin
                  rd_sdram_req <= 1'b0;
                  tmo_err      <= 1'b1;
                  state        <= GAP;
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
            end

            GAP: begin
               wd_cnt <= '0;
               state  <= IDLE;
            end

            default: begin
               wr_sdram_req <= 1'b0;
               rd_sdram_req <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule
